// File: rtl/whack_input_decoder_pkg.sv
// Shared types for the whack-a-mole input path: switch count, index width, event payload.
package whack_input_pkg;

  localparam int WHACK_NUM_INPUTS = 16;
  localparam int WHACK_INDEX_W    = 4;

  typedef struct packed {
    logic [WHACK_INDEX_W-1:0] index;
    logic                     dir;
  } whack_event_t;

  // Lowest set bit wins so simultaneous changes drain in ascending index order.
  function automatic logic [WHACK_INDEX_W-1:0] lowestSetIndex(input logic [WHACK_NUM_INPUTS-1:0] vec);
    logic [WHACK_INDEX_W-1:0] idx;
    idx = '0;
    for (int n = WHACK_NUM_INPUTS - 1; n >= 0; n--) begin
      if (vec[n]) idx = WHACK_INDEX_W'(n);
    end
    return idx;
  endfunction

endpackage

// File: rtl/whack_input_decoder_fifo.sv
// whack_event_fifo: show-ahead event FIFO; push and pop may coincide at any occupancy.
module whack_event_fifo
  import whack_input_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_pushValid,
  input  whack_event_t i_pushData,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output whack_event_t o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  whack_event_t r_mem [DEPTH];
  logic         w_empty;
  logic         w_pop;
  logic         w_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_valid = !w_empty;
  assign w_pop   = !w_empty && i_ready;
  assign w_push  = i_pushValid && (!o_full || w_pop);
  assign o_data  = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
  end

endmodule

// File: rtl/whack_input_decoder.sv
// whack_input_decoder: synchronizes, debounces and serializes 16 mole switches into change events.
// Define WHACK_DEBOUNCE_EN for tick-based debounce; otherwise the stable vector follows the synchronizer.
module whack_input_decoder
  import whack_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [WHACK_NUM_INPUTS-1:0] switches_i,
  input  logic                        event_ready_i,
  output logic                        event_valid_o,
  output logic [WHACK_INDEX_W-1:0]    event_index_o,
  output logic                        event_dir_o,
  output logic [WHACK_NUM_INPUTS-1:0] switches_stable_o,
  output logic                        overflow_o
);

  if (DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_paramCheck
    $error("whack_input_decoder: DEBOUNCE_CYCLES must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  logic [WHACK_NUM_INPUTS-1:0] r_sync1;
  logic [WHACK_NUM_INPUTS-1:0] r_sync2;
  logic [WHACK_NUM_INPUTS-1:0] w_stable;
  logic [WHACK_NUM_INPUTS-1:0] r_stableD;
  logic [WHACK_NUM_INPUTS-1:0] r_pending;
  logic [WHACK_NUM_INPUTS-1:0] w_changed;
  logic [WHACK_NUM_INPUTS-1:0] w_clear;
  logic [WHACK_INDEX_W-1:0]    w_pendIdx;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        r_overflow;
  whack_event_t                w_pushData;
  whack_event_t                w_head;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef WHACK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]            r_tickCount;
  logic                        w_tick;
  logic [WHACK_NUM_INPUTS-1:0] r_samplePrev;
  logic [WHACK_NUM_INPUTS-1:0] r_stable;
  logic [WHACK_NUM_INPUTS-1:0] w_agree;

  assign w_tick   = (r_tickCount == CNT_MAX);
  assign w_agree  = ~(r_sync2 ^ r_samplePrev);
  assign w_stable = r_stable;

  // A bit only moves once two consecutive ticks have seen the same level.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_tickCount  <= '0;
      r_samplePrev <= '0;
      r_stable     <= '0;
    end else begin
      r_tickCount <= w_tick ? '0 : r_tickCount + CNT_W'(1);
      if (w_tick) begin
        r_samplePrev <= r_sync2;
        r_stable     <= (r_sync2 & w_agree) | (r_stable & ~w_agree);
      end
    end
  end
`else
  assign w_stable = r_sync2;
`endif

  assign w_changed  = w_stable ^ r_stableD;
  assign w_pendIdx  = lowestSetIndex(r_pending);
  assign w_pop      = event_valid_o && event_ready_i;
  assign w_push     = (|r_pending) && (!w_full || w_pop);
  assign w_clear    = w_push ? (WHACK_NUM_INPUTS'(1) << w_pendIdx) : '0;
  assign w_pushData = {w_pendIdx, w_stable[w_pendIdx]};

  // A change landing on a still-pending bit merges into one event; direction is taken at push time.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_stableD  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_stableD <= w_stable;
      r_pending <= (r_pending & ~w_clear) | w_changed;
      if (|(w_changed & r_pending & ~w_clear)) r_overflow <= 1'b1;
    end
  end

  whack_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clock    (clock_i),
    .i_reset    (reset_i),
    .i_pushValid(w_push),
    .i_pushData (w_pushData),
    .o_full     (w_full),
    .o_valid    (event_valid_o),
    .i_ready    (event_ready_i),
    .o_data     (w_head)
  );

  assign event_index_o     = w_head.index;
  assign event_dir_o       = w_head.dir;
  assign switches_stable_o = w_stable;
  assign overflow_o        = r_overflow;

endmodule

// File: tb/tb_whack_input_decoder.sv
// Directed scoreboard bench for whack_input_decoder (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_whack_input_decoder;
  import whack_input_pkg::*;

  localparam int SETTLE = 24;
  localparam int DRAIN_BUDGET = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ready;
  logic [15:0] switches;
  logic        eventValid;
  logic [3:0]  eventIndex;
  logic        eventDir;
  logic [15:0] switchesStable;
  logic        overflow;

  whack_event_t sbQ[$];
  logic [15:0]  curSw;
  int           checks = 0;
  int           errors = 0;

  always #5 clock = ~clock;

  whack_input_decoder #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .switches_i       (switches),
    .event_ready_i    (ready),
    .event_valid_o    (eventValid),
    .event_index_o    (eventIndex),
    .event_dir_o      (eventDir),
    .switches_stable_o(switchesStable),
    .overflow_o       (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectEvent(input int idx, input logic dir);
    whack_event_t ev;
    ev.index = 4'(idx);
    ev.dir   = dir;
    sbQ.push_back(ev);
  endtask

  // Drives a new switch vector; every flipped bit is expected as one event in ascending order.
  task automatic applyStimulus(input logic [15:0] newSw, input bit expectEvents);
    @(posedge clock); #1;
    if (expectEvents) begin
      for (int i = 0; i < 16; i++) begin
        if (newSw[i] != curSw[i]) expectEvent(i, newSw[i]);
      end
    end
    switches = newSw;
    curSw    = newSw;
  endtask

  task automatic setReady(input logic v);
    @(posedge clock); #1;
    ready = v;
  endtask

  task automatic settle();
    repeat (SETTLE) @(posedge clock);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < DRAIN_BUDGET) begin
      @(posedge clock);
      n++;
    end
    #1;
    checkOutput({tag, "_leftover"}, 32'(sbQ.size()), 32'd0);
    settle();
    checkOutput({tag, "_idle"}, 32'(eventValid), 32'd0);
  endtask

  // Head is compared against the scoreboard every cycle it is valid, so stalls also prove the head holds.
  always @(negedge clock) begin
    if (!reset && eventValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedEvent", 32'(sbQ.size()), 32'd1);
      end else begin
        checkOutput("eventIndex", 32'(eventIndex), 32'(sbQ[0].index));
        checkOutput("eventDir", 32'(eventDir), 32'(sbQ[0].dir));
        if (ready) void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ready    = 1'b0;
    switches = 16'h0000;
    curSw    = 16'h0000;
    #1 reset = 1'b1;
    #1;
    checkOutput("rstValid", 32'(eventValid), 32'd0);
    checkOutput("rstIndex", 32'(eventIndex), 32'd0);
    checkOutput("rstDir", 32'(eventDir), 32'd0);
    checkOutput("rstStable", 32'(switchesStable), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] single switch on");
    setReady(1'b1);
    applyStimulus(16'h0020, 1'b1);
    waitDrain("sw5On");
    checkOutput("sw5Stable", 32'(switchesStable), 32'h0020);
    checkOutput("sw5Overflow", 32'(overflow), 32'd0);
    applyStimulus(16'h0000, 1'b1);
    waitDrain("sw5Off");

    $display("[TB] short glitch on switch 3");
    @(posedge clock); #1;
`ifndef WHACK_DEBOUNCE_EN
    expectEvent(3, 1'b1);
    expectEvent(3, 1'b0);
`endif
    switches = 16'h0008;
    repeat (3) @(posedge clock);
    #1 switches = 16'h0000;
    waitDrain("glitch");
    checkOutput("glitchStable", 32'(switchesStable), 32'h0000);

    $display("[TB] simultaneous burst 0x8421");
    setReady(1'b0);
    applyStimulus(16'h8421, 1'b1);
    settle();
    checkOutput("burstQueued", 32'(eventValid), 32'd1);
    setReady(1'b1);
    waitDrain("burst");
    checkOutput("burstStable", 32'(switchesStable), 32'h8421);
    applyStimulus(16'h0000, 1'b1);
    waitDrain("burstClear");

    $display("[TB] six switches against a four-entry queue");
    setReady(1'b0);
    applyStimulus(16'h1256, 1'b1);
    settle();
    checkOutput("sixQueued", 32'(eventValid), 32'd1);
    setReady(1'b1);
    waitDrain("six");
    checkOutput("sixOverflow", 32'(overflow), 32'd0);
    checkOutput("sixStable", 32'(switchesStable), 32'h1256);
    applyStimulus(16'h0000, 1'b1);
    waitDrain("sixClear");

    $display("[TB] switch 7 toggles while pending behind a full queue");
    setReady(1'b0);
    applyStimulus(16'h000F, 1'b1);
    settle();
    applyStimulus(16'h008F, 1'b0);
    settle();
    checkOutput("coalesceBefore", 32'(overflow), 32'd0);
    applyStimulus(16'h000F, 1'b0);
    expectEvent(7, 1'b0);
    settle();
    checkOutput("coalesceOverflow", 32'(overflow), 32'd1);
    setReady(1'b1);
    waitDrain("coalesce");
    checkOutput("coalesceStable", 32'(switchesStable), 32'h000F);

    $display("[TB] reset with events queued and switch 2 held");
    setReady(1'b0);
    applyStimulus(16'h0004, 1'b1);
    settle();
    checkOutput("preResetQueued", 32'(eventValid), 32'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("midResetValid", 32'(eventValid), 32'd0);
    checkOutput("midResetStable", 32'(switchesStable), 32'd0);
    checkOutput("midResetOverflow", 32'(overflow), 32'd0);
    sbQ.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    expectEvent(2, 1'b1);
    setReady(1'b1);
    waitDrain("afterReset");
    checkOutput("afterResetStable", 32'(switchesStable), 32'h0004);
    checkOutput("afterResetOverflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
